// File: rtl/ifu_fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
// Constant names mirror the core-wide defines.
package ifu_fetch_pkg;

  localparam int HOLD_W = 3;
  typedef logic [HOLD_W-1:0] hold_flag_t;

  localparam hold_flag_t HOLD_IF = 3'b010;

  localparam logic [31:0] INST_NOP = 32'h0000_0001;
  localparam logic [31:0] ZERO_WORD = 32'h0;
  localparam logic JUMP_DISABLE = 1'b0;
  localparam logic [31:0] CPU_RESET_ADDR = 32'h0;

  localparam logic [6:0] INST_JAL = 7'b1101111;
  localparam logic [6:0] INST_TYPE_B = 7'b1100011;

  localparam int DISC_W = 8;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] inst;
  } ifq_entry_t;

  function automatic logic [31:0] word_align(
    input logic [31:0] a
  );
    return a & 32'hFFFF_FFFC;
  endfunction

endpackage

// File: rtl/ifu_fetch_if.sv
// Instruction memory request/response bus.
// The master side is the fetch unit.
interface ifu_fetch_if;

  logic mem_req_o;
  logic [31:0] mem_addr_o;
  logic mem_gnt_i;
  logic mem_rvalid_i;
  logic [31:0] mem_rdata_i;

  modport master (
    output mem_req_o,
    output mem_addr_o,
    input mem_gnt_i,
    input mem_rvalid_i,
    input mem_rdata_i
  );

  modport slave (
    input mem_req_o,
    input mem_addr_o,
    output mem_gnt_i,
    output mem_rvalid_i,
    output mem_rdata_i
  );

endinterface

// File: rtl/ifu_bp_predecode.sv
// Static predictor: JAL and backward branches
// are taken; target is addr + immediate.
module ifu_bp_predecode
  import ifu_fetch_pkg::*;
(
  input logic [31:0] inst,
  input logic [31:0] addr,
  output logic taken,
  output logic [31:0] target
);

  logic [31:0] imm_j;
  logic [31:0] imm_b;
  logic is_jal;
  logic is_bwd;

  assign imm_j = {{11{inst[31]}}, inst[31],
                  inst[19:12], inst[20],
                  inst[30:21], 1'b0};
  assign imm_b = {{19{inst[31]}}, inst[31],
                  inst[7], inst[30:25],
                  inst[11:8], 1'b0};

  assign is_jal = inst[6:0] == INST_JAL;
  assign is_bwd = (inst[6:0] == INST_TYPE_B)
                  && inst[31];

  always_comb begin
    taken = 1'b0;
    target = addr + 32'd4;
    unique case (1'b1)
      is_jal: begin
        taken = 1'b1;
        target = addr + imm_j;
      end
      is_bwd: begin
        taken = 1'b1;
        target = addr + imm_b;
      end
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/ifu_fetch.sv
// Fetch unit: PC, in-order fetch queue,
// flush/discard tracking and static redirect.
module ifu_fetch
  import ifu_fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = CPU_RESET_ADDR,
  parameter int OUTSTANDING = 2
) (
  input logic clk,
  input logic rst,
  input logic jump_flag_i,
  input logic [31:0] jump_addr_i,
  input hold_flag_t hold_flag_i,
  ifu_fetch_if.master mem,
  output logic inst_valid_o,
  output logic [31:0] inst_o,
  output logic [31:0] inst_addr_o,
  output logic bp_result_o
);

  localparam int PW =
    (OUTSTANDING > 1) ? $clog2(OUTSTANDING) : 1;
  localparam int CW = $clog2(OUTSTANDING + 1);

  ifq_entry_t q [OUTSTANDING];
  logic [31:0] pc_q;
  logic [PW-1:0] head_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] fcnt_q;
  logic [DISC_W-1:0] disc_q;

  ifq_entry_t head;
  logic [CW-1:0] unret;
  logic [CW-1:0] u1;
  logic [DISC_W-1:0] d1;
  logic bp_taken;
  logic [31:0] bp_target;
  logic pop;
  logic redirect;
  logic req;
  logic gnt;
  logic drop;
  logic fill;
  logic [CW:0] tail_sum;
  logic [CW:0] fill_sum;
  logic [PW-1:0] tail_idx;
  logic [PW-1:0] fill_idx;
  logic [PW-1:0] head_next;

  assign head = q[head_q];
  assign unret = cnt_q - fcnt_q;
  assign inst_valid_o = !rst && (fcnt_q != '0);

  ifu_bp_predecode u_bp (
    .inst(head.inst),
    .addr(head.addr),
    .taken(bp_taken),
    .target(bp_target)
  );

  assign pop = inst_valid_o && !jump_flag_i
               && (hold_flag_i < HOLD_IF);
  assign redirect = pop && bp_taken;

  // A pop frees a slot for a same-cycle grant.
  assign req = !rst && !jump_flag_i
               && ((cnt_q < CW'(OUTSTANDING)) || pop);
  assign gnt = req && mem.mem_gnt_i;

  assign drop = mem.mem_rvalid_i && (disc_q != '0);
  assign fill = mem.mem_rvalid_i && (disc_q == '0)
                && (unret != '0);
  assign d1 = disc_q - DISC_W'(drop);
  assign u1 = unret - CW'(fill);

  assign tail_sum = (CW+1)'(head_q) + (CW+1)'(cnt_q);
  assign fill_sum = (CW+1)'(head_q) + (CW+1)'(fcnt_q);
  assign tail_idx = PW'(
    (tail_sum >= (CW+1)'(OUTSTANDING))
      ? tail_sum - (CW+1)'(OUTSTANDING) : tail_sum);
  assign fill_idx = PW'(
    (fill_sum >= (CW+1)'(OUTSTANDING))
      ? fill_sum - (CW+1)'(OUTSTANDING) : fill_sum);
  assign head_next =
    (head_q == PW'(OUTSTANDING - 1))
      ? '0 : head_q + 1'b1;

  assign mem.mem_req_o = req;
  assign mem.mem_addr_o = rst ? RESET_PC : pc_q;

  assign inst_o = inst_valid_o ? head.inst : INST_NOP;
  assign inst_addr_o =
    inst_valid_o ? head.addr : ZERO_WORD;
  assign bp_result_o =
    inst_valid_o ? bp_taken : JUMP_DISABLE;

  always_ff @(posedge clk) begin
    if (rst) begin
      pc_q <= RESET_PC;
      head_q <= '0;
      cnt_q <= '0;
      fcnt_q <= '0;
      disc_q <= '0;
    end else begin
      if (fill) q[fill_idx].inst <= mem.mem_rdata_i;
      if (gnt) q[tail_idx].addr <= pc_q;
      if (jump_flag_i) begin
        pc_q <= word_align(jump_addr_i);
        cnt_q <= '0;
        fcnt_q <= '0;
        disc_q <= d1 + DISC_W'(u1);
      end else if (redirect) begin
        // Same-cycle grant is younger and stale too.
        pc_q <= word_align(bp_target);
        cnt_q <= '0;
        fcnt_q <= '0;
        disc_q <= d1 + DISC_W'(u1) + DISC_W'(gnt);
      end else begin
        if (gnt) pc_q <= pc_q + 32'd4;
        cnt_q <= cnt_q - CW'(pop) + CW'(gnt);
        fcnt_q <= fcnt_q - CW'(pop) + CW'(fill);
        if (pop) head_q <= head_next;
        disc_q <= d1;
      end
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed cycle table plus a reactive-memory
// burst for the fetch unit.
module tb_ifu_fetch;
  import ifu_fetch_pkg::*;

  localparam logic [31:0] NOP = 32'h0000_0001;
  localparam logic [31:0] JAL = 32'hFF9F_F06F;
  localparam logic [31:0] BEQ = 32'hFE00_0EE3;

  logic clk;
  logic rst;
  logic jump_flag;
  logic [31:0] jump_addr;
  hold_flag_t hold;
  logic inst_valid;
  logic [31:0] inst;
  logic [31:0] inst_addr;
  logic bp_result;

  ifu_fetch_if bus();

  ifu_fetch dut (
    .clk(clk),
    .rst(rst),
    .jump_flag_i(jump_flag),
    .jump_addr_i(jump_addr),
    .hold_flag_i(hold),
    .mem(bus),
    .inst_valid_o(inst_valid),
    .inst_o(inst),
    .inst_addr_o(inst_addr),
    .bp_result_o(bp_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic rst;
    logic jmp;
    logic [31:0] ja;
    logic [2:0] hold;
    logic gnt;
    logic rv;
    logic [31:0] rd;
    logic req;
    logic [31:0] maddr;
    logic vld;
    logic [31:0] inst;
    logic [31:0] iaddr;
    logic bp;
  } vec_t;

  vec_t vq[$];
  int n_pass = 0;
  int n_total = 0;

  function automatic vec_t mk(
    input logic r, input logic j,
    input logic [31:0] ja, input logic [2:0] h,
    input logic g, input logic v,
    input logic [31:0] d, input logic rq,
    input logic [31:0] ma, input logic vl,
    input logic [31:0] in, input logic [31:0] ia,
    input logic b);
    vec_t t;
    t.rst = r; t.jmp = j; t.ja = ja; t.hold = h;
    t.gnt = g; t.rv = v; t.rd = d; t.req = rq;
    t.maddr = ma; t.vld = vl; t.inst = in;
    t.iaddr = ia; t.bp = b;
    return t;
  endfunction

  task automatic chk(input string name,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h",
               name, act, exp);
    else
      n_pass++;
  endtask

  task automatic burst();
    logic pend;
    logic [31:0] paddr;
    logic [31:0] exp_a;
    int first_gnt;
    int first_vld;
    int npop;
    @(negedge clk);
    rst = 1'b1; jump_flag = 1'b0; hold = '0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    pend = 1'b0; paddr = '0; exp_a = '0;
    first_gnt = -1; first_vld = -1; npop = 0;
    for (int c = 0; c < 20 && npop < 6; c++) begin
      @(negedge clk);
      rst = 1'b0;
      bus.mem_gnt_i = 1'b1;
      bus.mem_rvalid_i = pend;
      bus.mem_rdata_i =
        pend ? {paddr[19:0], 12'h013} : 32'h0;
      #1;
      if (bus.mem_req_o && first_gnt < 0)
        first_gnt = c;
      if (inst_valid) begin
        if (first_vld < 0) first_vld = c;
        chk($sformatf("burst addr%0d", npop),
            inst_addr, exp_a);
        chk($sformatf("burst inst%0d", npop),
            inst, {exp_a[19:0], 12'h013});
        exp_a = exp_a + 32'd4;
        npop++;
      end
      pend = bus.mem_req_o;
      paddr = bus.mem_addr_o;
    end
    chk("burst pops", 32'(npop), 32'd6);
    chk("burst latency",
        32'(first_vld - first_gnt), 32'd2);
  endtask

  initial begin
    rst = 1'b1; jump_flag = 1'b0; jump_addr = '0;
    hold = '0;
    bus.mem_gnt_i = 1'b0;
    bus.mem_rvalid_i = 1'b0;
    bus.mem_rdata_i = '0;

    // reset, back-to-back fetch, same-cycle reuse
    vq.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,NOP,0,0));
    vq.push_back(mk(1,0,0,0, 0,0,0, 0,0, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0, 1,0, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h13,
                    1,'h4, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h4013,
                    1,'h8, 1,'h13,'h0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h8013,
                    1,'hC, 1,'h4013,'h4,0));
    // hold for 5 cycles
    vq.push_back(mk(0,0,0,2, 1,1,'hC013,
                    0,'h10, 1,'h8013,'h8,0));
    for (int k = 0; k < 4; k++)
      vq.push_back(mk(0,0,0,2, 1,0,0,
                      0,'h10, 1,'h8013,'h8,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h10, 1,'h8013,'h8,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h10013,
                    1,'h14, 1,'hC013,'hC,0));
    vq.push_back(mk(0,0,0,2, 0,1,'h14013,
                    0,'h18, 1,'h10013,'h10,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h18, 1,'h10013,'h10,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h1C, 1,'h14013,'h14,0));
    // jump with two outstanding
    vq.push_back(mk(0,1,'h103,0, 1,0,0,
                    0,'h20, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'hDEAD0013,
                    1,'h100, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,'hBEEF0013,
                    1,'h104, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,'h00100013,
                    1,'h104, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,
                    1,'h104, 1,'h00100013,'h100,0));
    // JAL -8 at 0x20, backward branch at 0x18
    vq.push_back(mk(0,1,'h20,0, 1,0,0,
                    0,'h104, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h20, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,JAL,
                    1,'h24, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h28, 1,JAL,'h20,1));
    vq.push_back(mk(0,0,0,0, 1,1,'h24013,
                    1,'h18, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,'h28013,
                    1,'h1C, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,BEQ,
                    1,'h1C, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,3, 0,0,0,
                    1,'h1C, 1,BEQ,'h18,1));
    vq.push_back(mk(0,0,0,1, 0,0,0,
                    1,'h1C, 1,BEQ,'h18,1));
    vq.push_back(mk(0,0,0,0, 0,0,0,
                    1,'h14, 0,NOP,0,0));
    // rvalid with jump, then reset mid-burst
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h14, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,0,0,
                    1,'h18, 0,NOP,0,0));
    vq.push_back(mk(0,1,'h200,0, 1,1,'h14013,
                    0,'h1C, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 1,1,'h18013,
                    1,'h200, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,'h00200013,
                    1,'h204, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,2, 1,0,0,
                    1,'h204, 1,'h00200013,'h200,0));
    vq.push_back(mk(1,0,0,0, 1,1,'h204013,
                    0,'h0, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,1,'hBAD00013,
                    1,'h0, 0,NOP,0,0));
    vq.push_back(mk(0,0,0,0, 0,0,0,
                    1,'h0, 0,NOP,0,0));

    foreach (vq[i]) begin
      @(negedge clk);
      rst = vq[i].rst;
      jump_flag = vq[i].jmp;
      jump_addr = vq[i].ja;
      hold = vq[i].hold;
      bus.mem_gnt_i = vq[i].gnt;
      bus.mem_rvalid_i = vq[i].rv;
      bus.mem_rdata_i = vq[i].rd;
      #1;
      chk($sformatf("v%0d req", i),
          32'(bus.mem_req_o), 32'(vq[i].req));
      chk($sformatf("v%0d mem_addr", i),
          bus.mem_addr_o, vq[i].maddr);
      chk($sformatf("v%0d valid", i),
          32'(inst_valid), 32'(vq[i].vld));
      chk($sformatf("v%0d inst", i),
          inst, vq[i].inst);
      chk($sformatf("v%0d inst_addr", i),
          inst_addr, vq[i].iaddr);
      chk($sformatf("v%0d bp", i),
          32'(bp_result), 32'(vq[i].bp));
    end

    burst();

    $display("%0d/%0d checks passed",
             n_pass, n_total);
    $finish;
  end

endmodule
